// File: rtl/branch_resolve_predict_if.sv
// Fetch-side prediction lookup and MEM-side branch resolution bundle.
// res_valid is a one-way valid with no ready: the block consumes one resolve per cycle unconditionally.
interface branch_resolve_predict_if #(
    parameter int XLEN = 32
);
    logic            if_pred_taken;
    logic [XLEN-1:0] if_pc;
    logic            res_valid;
    logic            res_branch_flag;
    logic [2:0]      res_funct3;
    logic [XLEN-1:0] res_rs1;
    logic [XLEN-1:0] res_rs2;
    logic [XLEN-1:0] res_pc;
    logic [XLEN-1:0] res_target;
    logic            res_pred_taken;
    logic            PC_Src;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic            illegal_branch;
    logic [31:0]     branch_count;
    logic [31:0]     mispredict_count;

    modport master (
        output if_pc, res_valid, res_branch_flag, res_funct3, res_rs1, res_rs2,
               res_pc, res_target, res_pred_taken,
        input  if_pred_taken, PC_Src, redirect_pc, flush, illegal_branch,
               branch_count, mispredict_count
    );

    modport slave (
        input  if_pc, res_valid, res_branch_flag, res_funct3, res_rs1, res_rs2,
               res_pc, res_target, res_pred_taken,
        output if_pred_taken, PC_Src, redirect_pc, flush, illegal_branch,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_resolve_predict.sv
// Resolves RV32I conditional branches, trains a 2-bit counter BHT and issues
// a registered redirect/flush pulse on mispredicts.
module branch_resolve_predict #(
    parameter int         XLEN         = 32,
    parameter int         BHT_ENTRIES  = 16,
    parameter logic [1:0] COUNTER_INIT = 2'b01
) (
    input logic                    clk,
    input logic                    reset,
    branch_resolve_predict_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]      bht [BHT_ENTRIES];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] res_idx;

    logic            cond_legal;
    logic            actual_taken;
    logic            resolve;
    logic            legal_ev;
    logic            illegal_ev;
    logic            mispredict;

    logic            pc_src_q;
    logic            flush_q;
    logic            illegal_q;
    logic [XLEN-1:0] redirect_q;
    logic [31:0]     branch_cnt_q;
    logic [31:0]     mispredict_cnt_q;

    assign if_idx  = bus.if_pc[IDX_W+1:2];
    assign res_idx = bus.res_pc[IDX_W+1:2];

    // Lookup reads the stored counter only; a same-cycle update is not forwarded.
    assign bus.if_pred_taken = bht[if_idx][1];

    always_comb begin
        cond_legal   = 1'b1;
        actual_taken = 1'b0;
        case (bus.res_funct3)
            3'b000:  actual_taken = (bus.res_rs1 == bus.res_rs2);
            3'b001:  actual_taken = (bus.res_rs1 != bus.res_rs2);
            3'b100:  actual_taken = ($signed(bus.res_rs1) <  $signed(bus.res_rs2));
            3'b101:  actual_taken = ($signed(bus.res_rs1) >= $signed(bus.res_rs2));
            3'b110:  actual_taken = (bus.res_rs1 <  bus.res_rs2);
            3'b111:  actual_taken = (bus.res_rs1 >= bus.res_rs2);
            default: cond_legal   = 1'b0;
        endcase
    end

    assign resolve    = bus.res_valid && bus.res_branch_flag;
    assign legal_ev   = resolve && cond_legal;
    assign illegal_ev = resolve && !cond_legal;
    assign mispredict = legal_ev && (actual_taken != bus.res_pred_taken);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= COUNTER_INIT;
            end
            pc_src_q         <= 1'b0;
            flush_q          <= 1'b0;
            illegal_q        <= 1'b0;
            redirect_q       <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            pc_src_q  <= mispredict;
            flush_q   <= mispredict;
            illegal_q <= illegal_ev;
            if (mispredict) begin
                redirect_q <= actual_taken ? bus.res_target : bus.res_pc + XLEN'(4);
                if (mispredict_cnt_q != '1) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            end
            if (legal_ev) begin
                if (actual_taken && bht[res_idx] != 2'b11) begin
                    bht[res_idx] <= bht[res_idx] + 2'd1;
                end else if (!actual_taken && bht[res_idx] != 2'b00) begin
                    bht[res_idx] <= bht[res_idx] - 2'd1;
                end
                if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 32'd1;
            end
        end
    end

    assign bus.PC_Src           = pc_src_q;
    assign bus.flush            = flush_q;
    assign bus.illegal_branch   = illegal_q;
    assign bus.redirect_pc      = redirect_q;
    assign bus.branch_count     = branch_cnt_q;
    assign bus.mispredict_count = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_resolve_predict.sv
// Randomised and directed bench for branch_resolve_predict with a queue scoreboard
// and a table-level reference model of the predictor.
module tb_branch_resolve_predict;
  localparam int XLEN = 32;
  localparam int ENTRIES = 16;

  typedef struct packed {
    logic        pc_src;
    logic        flush;
    logic        illegal;
    logic [31:0] redirect;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
    logic [31:0] tbl;   // 16 x 2-bit counters after this cycle's update
  } exp_t;

  logic clk;
  logic reset;
  branch_resolve_predict_if #(.XLEN(XLEN)) bus ();

  branch_resolve_predict #(.XLEN(XLEN), .BHT_ENTRIES(ENTRIES), .COUNTER_INIT(2'b01)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int          m_cnt[ENTRIES];
  logic [31:0] m_red;
  logic [31:0] m_b;
  logic [31:0] m_m;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
  endtask

  // returns {legal, taken}
  function automatic logic [1:0] ref_cond(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0: return {1'b1, a == b};
      3'd1: return {1'b1, a != b};
      3'd4: return {1'b1, sa < sb};
      3'd5: return {1'b1, sa >= sb};
      3'd6: return {1'b1, a < b};
      3'd7: return {1'b1, a >= b};
      default: return 2'b00;
    endcase
  endfunction

  // driver: applies one cycle of stimulus and pushes the expected response
  task automatic drive(input logic rst, input logic valid, input logic bf, input logic [2:0] f3,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic pred, input logic [31:0] probe);
    exp_t e;
    logic [1:0] lt;
    logic r, mis;
    int idx;
    @(posedge clk);
    #1;
    reset = rst;
    bus.res_valid = valid;
    bus.res_branch_flag = bf;
    bus.res_funct3 = f3;
    bus.res_rs1 = rs1;
    bus.res_rs2 = rs2;
    bus.res_pc = pc;
    bus.res_target = tgt;
    bus.res_pred_taken = pred;
    bus.if_pc = probe;
    e = '0;
    if (rst) begin
      foreach (m_cnt[i]) m_cnt[i] = 1;
      m_red = 0;
      m_b = 0;
      m_m = 0;
    end else begin
      r = valid && bf;
      lt = ref_cond(f3, rs1, rs2);
      idx = (pc / 4) % ENTRIES;
      e.illegal = r && !lt[1];
      mis = r && lt[1] && (lt[0] != pred);
      if (r && lt[1]) begin
        if (lt[0]) m_cnt[idx] = (m_cnt[idx] < 3) ? m_cnt[idx] + 1 : 3;
        else       m_cnt[idx] = (m_cnt[idx] > 0) ? m_cnt[idx] - 1 : 0;
        if (m_b != 32'hFFFF_FFFF) m_b = m_b + 1;
      end
      if (mis) begin
        if (m_m != 32'hFFFF_FFFF) m_m = m_m + 1;
        m_red = lt[0] ? tgt : pc + 32'd4;
      end
      e.pc_src = mis;
      e.flush = mis;
    end
    e.redirect = m_red;
    e.bcnt = m_b;
    e.mcnt = m_m;
    for (int i = 0; i < ENTRIES; i++) e.tbl[2*i +: 2] = 2'(m_cnt[i]);
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [31:0] probe);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 0, 0, 1'b0, probe);
  endtask

  task automatic br(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                    input logic [31:0] pc, input logic [31:0] tgt, input logic pred,
                    input logic [31:0] probe);
    drive(1'b0, 1'b1, 1'b1, f3, rs1, rs2, pc, tgt, pred, probe);
  endtask

  // scoreboard monitor: the item pushed last cycle is due after this edge
  initial begin
    exp_t e;
    int idx;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        @(negedge clk);
        check("pc_src", 32'(bus.PC_Src), 32'(e.pc_src));
        check("flush", 32'(bus.flush), 32'(e.flush));
        check("illegal_branch", 32'(bus.illegal_branch), 32'(e.illegal));
        check("redirect_pc", bus.redirect_pc, e.redirect);
        check("branch_count", bus.branch_count, e.bcnt);
        check("mispredict_count", bus.mispredict_count, e.mcnt);
        idx = (bus.if_pc / 4) % ENTRIES;
        check("if_pred_taken", 32'(bus.if_pred_taken), 32'(e.tbl[2*idx+1]));
      end
    end
  end

  // stimulus
  initial begin
    logic [31:0] a, b;
    reset = 1'b1;
    bus.if_pc = 0;
    bus.res_valid = 0;
    bus.res_branch_flag = 0;
    bus.res_funct3 = 0;
    bus.res_rs1 = 0;
    bus.res_rs2 = 0;
    bus.res_pc = 0;
    bus.res_target = 0;
    bus.res_pred_taken = 0;
    foreach (m_cnt[i]) m_cnt[i] = 1;
    m_red = 0;
    m_b = 0;
    m_m = 0;

    repeat (3) drive(1'b1, 1'b0, 1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 0);

    // sweep every entry after reset
    for (int i = 0; i < ENTRIES; i++) idle(32'(i * 4));

    // beq taken, predicted not-taken, entry 0 trained to 2
    br(3'd0, 32'h5, 32'h5, 32'h40, 32'h100, 1'b0, 32'h0);
    idle(32'h0);
    idle(32'h40);

    // signed vs unsigned less-than on the same operands
    br(3'd4, 32'hFFFF_FFFF, 32'h1, 32'h80, 32'h200, 1'b0, 32'h80);
    br(3'd6, 32'hFFFF_FFFF, 32'h1, 32'h80, 32'h300, 1'b0, 32'h80);
    idle(32'h80);

    // saturation walk on entry 2
    repeat (4) br(3'd1, 32'h1, 32'h2, 32'h8, 32'h400, 1'b1, 32'h8);
    repeat (3) br(3'd1, 32'h7, 32'h7, 32'h8, 32'h400, 1'b1, 32'h8);
    idle(32'h8);

    // illegal condition codes
    br(3'd2, 32'h1, 32'h1, 32'hC, 32'h500, 1'b0, 32'hC);
    br(3'd3, 32'h1, 32'h2, 32'hC, 32'h500, 1'b1, 32'hC);
    idle(32'hC);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 4) == 0) b = {$urandom_range(0, 1) ? 1'b1 : 1'b0, b[30:0]};
      drive(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 3'($urandom_range(0, 7)),
            a, b, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom);
    end

    // reset dominates a mispredicting bge in the same cycle
    drive(1'b1, 1'b1, 1'b1, 3'd5, 32'h5, 32'h1, 32'h44, 32'h600, 1'b0, 32'h44);
    for (int i = 0; i < ENTRIES; i++) idle(32'(i * 4));

    for (int n = 0; n < 50; n++) begin
      a = $urandom_range(0, 7);
      b = $urandom_range(0, 7);
      br(3'($urandom_range(0, 7)), a, b, 32'($urandom_range(0, 63)), $urandom,
         1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)));
    end
    idle(32'h0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d items still queued, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
